// File: rtl/line_window_buffer.sv
// Streaming 3-row line buffer: turns a raster pixel stream into vertical 3-pixel
// columns for the convolution stage, flagging full 3x3 windows and end of frame.
module line_window_buffer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PIX_W-1:0]           in_pix,
    output logic                       out_valid,
    output logic                       win_valid,
    output logic [3*PIX_W-1:0]         out_col,
    output logic [$clog2(IMG_W)-1:0]   col_idx,
    output logic [$clog2(IMG_H)-1:0]   row_idx,
    output logic                       frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];

    logic last_col, last_row;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));

    // Rows 0 and 1 only fill the line memories; rows >= 2 stream valid columns.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_col    <= '0;
            col_idx    <= '0;
            row_idx    <= '0;
        end else if (in_valid) begin
            out_col    <= {lb1[col], lb0[col], in_pix};
            col_idx    <= col;
            row_idx    <= row;
            out_valid  <= (row >= RW'(2));
            win_valid  <= (row >= RW'(2)) && (col >= CW'(2));
            frame_done <= last_row && last_col;
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end else begin
            out_valid  <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    // Line memories are never cleared; the row gating keeps stale data from
    // ever being flagged valid. Writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (in_valid && rst) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_pix;
        end
    end
endmodule

// File: tb/tb_line_window_buffer.sv
// Randomized and directed bench for line_window_buffer against a per-column
// pixel-history reference model (IMG_W = IMG_H = 4).
module tb_line_window_buffer;
    localparam int W = 4;
    localparam int H = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_pix;
    logic        out_valid, win_valid, frame_done;
    logic [47:0] out_col;
    logic [1:0]  col_idx;
    logic [1:0]  row_idx;

    line_window_buffer #(.IMG_W(W), .IMG_H(H), .PIX_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pix(in_pix),
        .out_valid(out_valid), .win_valid(win_valid), .out_col(out_col),
        .col_idx(col_idx), .row_idx(row_idx), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the two most recent pixels seen at each column address,
    // plus a count of pixels accepted since reset within the current frame.
    logic [15:0] h0 [W];
    logic [15:0] h1 [W];
    int          cnt;
    logic        e_v, e_w, e_d;
    logic [47:0] e_col;
    int          e_ci, e_ri;

    task automatic model_reset();
        cnt = 0; e_v = 0; e_w = 0; e_d = 0; e_col = '0; e_ci = 0; e_ri = 0;
    endtask

    task automatic model_accept(input logic [15:0] px);
        int c, r;
        c = cnt % W;
        r = cnt / W;
        e_col = {h1[c], h0[c], px};
        h1[c] = h0[c];
        h0[c] = px;
        e_ci = c; e_ri = r;
        e_v = (r >= 2);
        e_w = (r >= 2) && (c >= 2);
        e_d = (r == H - 1) && (c == W - 1);
        cnt = (cnt + 1) % (W * H);
    endtask

    task automatic compare_all();
        chk("out_valid", out_valid, e_v);
        chk("win_valid", win_valid, e_w);
        chk("frame_done", frame_done, e_d);
        chk("col_idx", col_idx, e_ci);
        chk("row_idx", row_idx, e_ri);
        chk("out_col_cur", out_col[15:0], e_col[15:0]);
        if (e_v) chk("out_col_full", out_col, e_col);
    endtask

    task automatic step(input logic v, input logic [15:0] px);
        @(negedge clk);
        in_valid = v;
        in_pix   = px;
        @(posedge clk);
        if (v) model_accept(px);
        else begin e_v = 0; e_w = 0; e_d = 0; end
        #1;
        compare_all();
    endtask

    function automatic logic [15:0] rc_pix(input int p);
        return 16'((p / W) * 16'h0100 + (p % W));
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_wv"}, win_valid, 0);
        chk({tag, "_fd"}, frame_done, 0);
        chk({tag, "_col"}, out_col, 0);
        chk({tag, "_ci"}, col_idx, 0);
        chk({tag, "_ri"}, row_idx, 0);
    endtask

    initial begin
        int nv, nw, first;
        for (int i = 0; i < W; i++) begin h0[i] = '0; h1[i] = '0; end
        model_reset();
        rst = 1'b0; in_valid = 1'b0; in_pix = '0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst = 1'b1;

        // Continuous frame with directed spot checks
        nv = 0; nw = 0;
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, rc_pix(p));
            nv += int'(out_valid); nw += int'(win_valid);
            if (p == 8)  chk("first_valid_col", out_col, 48'h0000_0100_0200);
            if (p == 10) begin
                chk("first_win_col", out_col, 48'h0002_0102_0202);
                chk("first_win_flag", win_valid, 1);
            end
            if (p == 15) begin
                chk("last_col", out_col, 48'h0103_0203_0303);
                chk("last_done", frame_done, 1);
                chk("last_ri", row_idx, 3);
                chk("last_ci", col_idx, 3);
            end
        end
        chk("n_out_valid", nv, 8);
        chk("n_win_valid", nw, 4);

        // Second frame back-to-back: wrap and line-memory reuse
        nv = 0;
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, rc_pix(p));
            if (p == 0) chk("done_one_cycle", frame_done, 0);
            if (p < 8) nv += int'(out_valid);
            if (p == 9) chk("f2_col21", out_col, 48'h0001_0101_0201);
        end
        chk("f2_early_valid", nv, 0);

        // Gapped frame: 1,0,1,0 pattern, out_col must hold across gaps
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, rc_pix(p));
            step(1'b0, 16'hdead);
            chk("gap_ov", out_valid, 0);
            if (p == 9) chk("gap_hold_col21", out_col, 48'h0001_0101_0201);
        end

        // Asynchronous reset mid-frame, after pixel (2,1)
        for (int p = 0; p < 10; p++) step(1'b1, rc_pix(p));
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk) in_valid = 1'b1; in_pix = 16'hbeef;
        @(posedge clk);
        #1 check_zero("rst_held");
        @(negedge clk) begin rst = 1'b1; in_valid = 1'b0; end

        first = -1;
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, 16'(16'h1000 + p));
            if (out_valid && first < 0) first = p;
        end
        chk("first_valid_after_rst", first, 8);

        // Randomized stream with random gaps
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 16'($urandom));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/line_window_buffer.md
# line_window_buffer

Streaming 3-row line buffer that sits directly upstream of the convolution/ReLU/pooling unit. It accepts a raster-order stream of 16-bit pixels and emits one 48-bit vertical column per accepted pixel. The column holds the current pixel plus the two pixels directly above it, which is the packed format the convolution stage consumes on its pixel input. It also flags when a full 3x3 window and the end of a frame are available.

## Interface
Parameters:
- IMG_W, 28, pixels per image row (≥3)
- IMG_H, 28, rows per image frame (≥3)
- PIX_W, 16, pixel width (fixed at 16 for this design; out_col is 3*PIX_W)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_pix is valid this cycle and is accepted
- in_pix  input  16  incoming pixel, raster order (row-major)
- out_valid  output  1  out_col valid (current row ≥ 2)
- win_valid  output  1  out_valid and current column ≥ 2 (full 3x3 window present downstream)
- out_col  output  48  [47:32] = row r-2, [31:16] = row r-1, [15:0] = row r, all at the same column
- col_idx  output  log2(IMG_W)  column of the pixel in out_col
- row_idx  output  log2(IMG_H)  row of the pixel in out_col
- frame_done  output  1  one-cycle pulse with the last pixel of a frame

## Operation
- Internal state:
  - Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1).
  - Two line memories, lb0 (row r-1) and lb1 (row r-2), each IMG_W x 16, addressed by col.
- On a rising edge with in_valid=1:
  - out_col <= {lb1[col], lb0[col], in_pix}.
  - lb1[col] <= lb0[col]; lb0[col] <= in_pix. This is a read-before-write on the same address in the same cycle.
  - col_idx <= col; row_idx <= row.
  - out_valid <= (row ≥ 2); win_valid <= (row ≥ 2) && (col ≥ 2).
  - frame_done <= (row == IMG_H-1) && (col == IMG_W-1).
  - col increments. At IMG_W-1 it wraps to 0 and row increments. At row IMG_H-1 with col IMG_W-1, both wrap to 0 for the next frame.
- On a rising edge with in_valid=0:
  - Counters and memories hold.
  - out_valid, win_valid and frame_done <= 0.
  - out_col, col_idx and row_idx hold their last values.
- Line memory contents are not cleared on reset or at frame boundaries. Stale data is never flagged valid because of the row ≥ 2 gating.
- Row/column state machine, implicit in the counters:
  - FILL0 (row 0) -> FILL1 (row 1) -> STREAM (rows 2..IMG_H-1) -> FILL0 on frame wrap.
  - out_valid can be 1 only in STREAM.
- Pixel data is passed unmodified. There is no arithmetic on pixel values.

## Timing
- Latency: a pixel accepted at edge N appears in out_col[15:0] after edge N. All outputs are registered, so latency is 1 cycle.
- Throughput: one pixel per clock. Arbitrary in_valid gaps are allowed mid-row and mid-frame with no loss or reordering.
- No backpressure. The downstream stage must accept every out_valid cycle.
- Reset (rst=0, asynchronous): immediately out_valid=0, win_valid=0, frame_done=0, out_col=0, col_idx=0, row_idx=0, col=0, row=0.
- Reset deassertion is synchronous to clk (external synchroniser). The first pixel after reset is row 0, col 0.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as row 0, col 0, and out_valid stays low for the next 2*IMG_W accepted pixels.
- frame_done coincides with the out_valid=1 cycle of pixel (IMG_H-1, IMG_W-1). The next accepted pixel is (0,0) with out_valid=0.
- Row wrap: at col IMG_W-1 -> 0, win_valid drops for columns 0 and 1 of the new row.

## Test plan
Parameters IMG_W=4, IMG_H=4. The stimulus pixel value is 16'h0100*row + col.

- Continuous stream of 16 pixels:
  - out_valid first rises on the cycle after pixel (2,0), with out_col = {16'h0000, 16'h0100, 16'h0200}.
  - win_valid first rises for (2,2), with out_col = {16'h0002, 16'h0102, 16'h0202}.
  - Exactly 8 out_valid cycles and 4 win_valid cycles occur.
- Last pixel (3,3): out_col = {16'h0103, 16'h0203, 16'h0303}, frame_done=1 for exactly one cycle, row_idx=3, col_idx=3.
- Two back-to-back frames:
  - The second frame's first 8 pixels produce out_valid=0.
  - Second-frame pixel (2,1) gives out_col = {16'h0001, 16'h0101, 16'h0201}. This checks wrap and memory reuse.
- in_valid toggled 1,0,1,0 through the frame: outputs match the continuous case value-for-value. out_valid is 0 in every gap cycle and out_col holds its value.
- Reset asserted after pixel (2,1), then released:
  - All outputs read 0 while rst=0.
  - A new 16-pixel frame of value 16'h1000+p yields its first out_valid only after its own 8th pixel. No old data is flagged valid.
- Reset asserted asynchronously between clock edges: outputs clear before the next rising edge.
